// File: rtl/sysfiltr_cpu_debug_slave_cmdq_if.sv
// Command-queue read port of the CPU debug slave: head entry plus valid/ready.
// The queue drives it through the master modport; the OCI/break/trace
// consumer uses the slave modport.
interface sysfiltr_cpu_debug_slave_cmdq_if #(
    parameter int IR_W = 2,
    parameter int SR_W = 38
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic            cmd_act;
    logic [SR_W-1:0] cmd_jdo;

    modport master (
        output cmd_valid,
        output cmd_ir,
        output cmd_act,
        output cmd_jdo,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ir,
        input  cmd_act,
        input  cmd_jdo,
        output cmd_ready
    );
endinterface

// File: rtl/sysfiltr_cpu_debug_slave_cmdq.sv
// System-clock side of the CPU debug slave. It synchronises the virtual-JTAG
// update strobes, latches IR and the scanned data word, and queues each data
// update for the debug core. The queue is DEPTH entries deep and its head is
// read first-word-fall-through.
// Optional feature: define DEBUG_SLAVE_PARITY_EN to reject data updates whose
// sr[SR_W-1] is not the odd parity of sr[SR_W-2:0].
module sysfiltr_cpu_debug_slave_cmdq #(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34,
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               vs_uir,
    input  logic                               vs_udr,
    input  logic [IR_W-1:0]                    ir_in,
    input  logic [SR_W-1:0]                    sr,
    sysfiltr_cpu_debug_slave_cmdq_if.master    cmd,
    output logic [SR_W-1:0]                    jdo,
    output logic [IR_W-1:0]                    ir_latched,
    output logic [LVL_W-1:0]                   level,
    output logic                               overflow,
    input  logic                               clr_overflow,
    output logic                               parity_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic            act;
        logic [SR_W-1:0] jdo;
    } entry_t;

    // Strobe synchronisers. fill marks that the synchroniser pipeline holds
    // real samples rather than reset zeros, so a strobe held high through
    // reset release is never mistaken for a low level.
    logic [SYNC_STAGES-1:0] fill;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_prev;
    logic                   udr_prev;
    logic                   uir_armed;
    logic                   udr_armed;
    logic                   uir_rise;
    logic                   udr_rise;

    logic                   sr_bad;
    logic                   udr_acc;
    logic                   valid;
    logic                   full;
    logic                   push;
    logic                   pop;

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    entry_t                 mem [DEPTH];
    entry_t                 head;
    entry_t                 hold;
    entry_t                 out_entry;

    // Synchronise both strobes and arm edge detection once a real low is seen.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill      <= '0;
            uir_sync  <= '0;
            udr_sync  <= '0;
            uir_prev  <= 1'b0;
            udr_prev  <= 1'b0;
            uir_armed <= 1'b0;
            udr_armed <= 1'b0;
        end else begin
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_prev  <= uir_sync[SYNC_STAGES-1];
            udr_prev  <= udr_sync[SYNC_STAGES-1];
            uir_armed <= uir_armed | (fill[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
            udr_armed <= udr_armed | (fill[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);
        end
    end

    assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_prev & uir_armed;
    assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_prev & udr_armed;

`ifdef DEBUG_SLAVE_PARITY_EN
    // Good words have odd overall parity including the parity bit itself.
    assign sr_bad = ~(^sr);

    // One-cycle flag for a data update rejected on parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= udr_rise & sr_bad;
        end
    end
`else
    assign sr_bad     = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign udr_acc = udr_rise & ~sr_bad;
    assign valid   = (level != '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop     = valid & cmd.cmd_ready;
    assign push    = udr_acc & (~full | pop);

    // Latched registers, queue pointers, occupancy, sticky overflow and the
    // copy of the last popped head.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_latched <= '0;
            jdo        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            hold       <= '0;
        end else begin
            if (uir_rise) begin
                ir_latched <= ir_in;
            end
            if (udr_acc) begin
                jdo <= sr;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                hold   <= head;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (udr_acc & full & ~pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Queue storage; the captured IR is the value before any same-cycle UIR.
    // NOTE: storage is deliberately not reset; level and the pointers decide
    // what is valid, and the visible head falls back to the reset hold copy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ir: ir_latched, act: sr[ACT_BIT], jdo: sr};
        end
    end

    assign head = mem[rd_ptr];

    // Show the live head while valid, otherwise hold the last popped entry.
    // NOTE: the default assignment first keeps this purely combinational.
    always_comb begin
        out_entry = hold;
        if (valid) begin
            out_entry = head;
        end
    end

    assign cmd.cmd_valid = valid;
    assign cmd.cmd_ir    = out_entry.ir;
    assign cmd.cmd_act   = out_entry.act;
    assign cmd.cmd_jdo   = out_entry.jdo;

endmodule

// File: tb/tb_sysfiltr_cpu_debug_slave_cmdq.sv
// Directed bench for the CPU debug slave command queue (default parameters).
module tb_sysfiltr_cpu_debug_slave_cmdq;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_uir;
    logic        vs_udr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [37:0] jdo;
    logic [1:0]  ir_latched;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_overflow;
    logic        parity_err;

    int tests  = 0;
    int failed = 0;

    int pe_cycles;
    logic pe_clr = 1'b1;

    sysfiltr_cpu_debug_slave_cmdq_if #(.IR_W(2), .SR_W(38)) cmd_if ();

    sysfiltr_cpu_debug_slave_cmdq dut (
        .clk          (clk),
        .reset        (reset),
        .vs_uir       (vs_uir),
        .vs_udr       (vs_udr),
        .ir_in        (ir_in),
        .sr           (sr),
        .cmd          (cmd_if),
        .jdo          (jdo),
        .ir_latched   (ir_latched),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Count clock cycles during which parity_err is high.
    always @(posedge clk) begin
        if (pe_clr) pe_cycles <= 0;
        else        pe_cycles <= pe_cycles + int'(parity_err);
    end

    typedef struct {
        logic [1:0]  ir;
        logic        act;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Build a scan word with correct odd parity in bit 37.
    function automatic logic [37:0] mk_sr(input logic act, input logic [31:0] word);
        logic [37:0] v;
        v = '0;
        v[31:0] = word;
        v[34] = act;
        v[37] = ~(^v[36:0]);
        return v;
    endfunction

    task automatic uir_pulse(input logic [1:0] ir);
        ir_in = ir;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(4);
    endtask

    task automatic udr_pulse(input logic [37:0] v);
        sr = v;
        vs_udr = 1'b1;
        tick(4);
        vs_udr = 1'b0;
        tick(4);
    endtask

    task automatic pop_check(input string name, input vec_t v);
        check({name, " valid"}, cmd_if.cmd_valid, 1'b1);
        check({name, " ir"}, cmd_if.cmd_ir, v.ir);
        check({name, " act"}, cmd_if.cmd_act, v.act);
        check({name, " jdo"}, cmd_if.cmd_jdo, mk_sr(v.act, v.word));
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
    endtask

    logic [37:0] w;
    logic [37:0] jdo_before;
    logic [2:0]  lvl_before;

    initial begin
        vecs[0] = '{2'd1, 1'b1, 32'h1111_1111};
        vecs[1] = '{2'd2, 1'b0, 32'h2222_2222};
        vecs[2] = '{2'd3, 1'b1, 32'h3333_3333};
        vecs[3] = '{2'd0, 1'b0, 32'h4444_4444};
        vecs[4] = '{2'd2, 1'b1, 32'h5555_5555};

        vs_uir = 1'b0;
        vs_udr = 1'b0;
        ir_in = '0;
        sr = '0;
        clr_overflow = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        reset = 1'b1;
        tick(2);
        pe_clr = 1'b0;
        tick(1);

        // Reset values while reset is still asserted.
        check("rst cmd_valid", cmd_if.cmd_valid, 1'b0);
        check("rst cmd_ir", cmd_if.cmd_ir, 2'd0);
        check("rst cmd_act", cmd_if.cmd_act, 1'b0);
        check("rst cmd_jdo", cmd_if.cmd_jdo, 38'd0);
        check("rst jdo", jdo, 38'd0);
        check("rst ir_latched", ir_latched, 2'd0);
        check("rst level", level, 3'd0);
        check("rst overflow", overflow, 1'b0);
        check("rst parity_err", parity_err, 1'b0);
        reset = 1'b0;
        tick(5);

        // Single command and its three-edge latency.
        uir_pulse(2'd2);
        check("t1 ir_latched", ir_latched, 2'd2);
        w = mk_sr(1'b1, 32'hDEAD_BEEF);
        sr = w;
        vs_udr = 1'b1;
        tick();
        check("t1 valid edge1", cmd_if.cmd_valid, 1'b0);
        tick();
        check("t1 valid edge2", cmd_if.cmd_valid, 1'b0);
        tick();
        check("t1 valid edge3", cmd_if.cmd_valid, 1'b1);
        check("t1 cmd_ir", cmd_if.cmd_ir, 2'd2);
        check("t1 cmd_act", cmd_if.cmd_act, 1'b1);
        check("t1 cmd_jdo lo", cmd_if.cmd_jdo[31:0], 32'hDEAD_BEEF);
        check("t1 jdo", jdo, w);
        check("t1 level", level, 3'd1);
        tick();
        vs_udr = 1'b0;
        tick(4);
        check("t1 level stable", level, 3'd1);
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
        check("t1 level popped", level, 3'd0);
        check("t1 valid popped", cmd_if.cmd_valid, 1'b0);
        check("t1 cmd_jdo held", cmd_if.cmd_jdo, w);

        // Five updates into a four-entry queue with no consumer.
        for (int i = 0; i < 5; i++) begin
            uir_pulse(vecs[i].ir);
            udr_pulse(mk_sr(vecs[i].act, vecs[i].word));
        end
        check("ovf level", level, 3'd4);
        check("ovf overflow", overflow, 1'b1);
        check("ovf jdo", jdo, mk_sr(vecs[4].act, vecs[4].word));
        for (int i = 0; i < 4; i++) begin
            pop_check($sformatf("ovf drain%0d", i), vecs[i]);
        end
        check("ovf drained level", level, 3'd0);
        check("ovf sticky", overflow, 1'b1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf cleared", overflow, 1'b0);

        // Full queue with a pop in the same cycle as the fifth push.
        for (int i = 0; i < 4; i++) begin
            uir_pulse(vecs[i].ir);
            udr_pulse(mk_sr(vecs[i].act, vecs[i].word));
        end
        check("fullpop pre level", level, 3'd4);
        uir_pulse(vecs[4].ir);
        sr = mk_sr(vecs[4].act, vecs[4].word);
        vs_udr = 1'b1;
        tick(2);
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
        check("fullpop level", level, 3'd4);
        check("fullpop overflow", overflow, 1'b0);
        tick();
        vs_udr = 1'b0;
        tick(4);
        for (int i = 1; i < 5; i++) begin
            pop_check($sformatf("fullpop drain%0d", i), vecs[i]);
        end
        check("fullpop empty", level, 3'd0);

        // UIR and UDR rising in the same cycle.
        uir_pulse(2'd1);
        check("same ir pre", ir_latched, 2'd1);
        ir_in = 2'd3;
        w = mk_sr(1'b0, 32'hCAFE_0001);
        sr = w;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        tick(4);
        check("same cmd_ir", cmd_if.cmd_ir, 2'd1);
        check("same ir_latched", ir_latched, 2'd3);
        check("same cmd_jdo", cmd_if.cmd_jdo, w);
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;

        // Update with wrong parity.
        w = mk_sr(1'b1, 32'h0BAD_0BAD);
        w[37] = ~w[37];
        jdo_before = jdo;
        lvl_before = level;
        pe_clr = 1'b1;
        tick();
        pe_clr = 1'b0;
        udr_pulse(w);
`ifdef DEBUG_SLAVE_PARITY_EN
        check("par bad pulse cycles", pe_cycles, 1);
        check("par bad level", level, lvl_before);
        check("par bad jdo", jdo, jdo_before);
        w = mk_sr(1'b1, 32'h600D_600D);
        udr_pulse(w);
        check("par good level", level, lvl_before + 3'd1);
        check("par good jdo", jdo, w);
        check("par good cycles", pe_cycles, 1);
`else
        check("par off cycles", pe_cycles, 0);
        check("par off level", level, lvl_before + 3'd1);
        check("par off jdo", jdo, w);
`endif
        check("par queued", level != 3'd0, 1'b1);

        // Reset mid-operation with vs_udr held high across release.
        vs_udr = 1'b1;
        do_reset();
        tick(2);
        check("held level", level, 3'd0);
        check("held valid", cmd_if.cmd_valid, 1'b0);
        check("held jdo", jdo, 38'd0);
        check("held overflow", overflow, 1'b0);
        vs_udr = 1'b0;
        tick(4);
        check("held no push", level, 3'd0);
        w = mk_sr(1'b0, 32'h1234_5678);
        udr_pulse(w);
        check("held one push", level, 3'd1);
        check("held push jdo", cmd_if.cmd_jdo, w);
        tick(4);
        check("held still one", level, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sysfiltr_cpu_debug_slave_cmdq.md
# sysfiltr_cpu_debug_slave_cmdq

Parametrised system-clock side of the CPU debug slave. It samples the virtual-JTAG update strobes (UIR/UDR) asynchronously, latches the instruction register and the scanned data word, and classifies each update as action or no-action. Updates go into a DEPTH-entry command queue, which the OCI/break/trace logic drains over a valid/ready handshake. It sits between the virtual-JTAG TCK-side shift logic and the CPU debug core. It replaces the fixed-width, unbuffered take_action strobes.

## Interface
- IR_W, 2, instruction register width; command codes 0..2**IR_W-1
- SR_W, 38, scan data width
- DEPTH, 4, queue entries; power of two, >=2
- SYNC_STAGES, 2, synchronizer flops per strobe; >=2
- ACT_BIT, 34, sr bit selecting action (1) or no-action (0); < SR_W-1

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- vs_uir  in  1  virtual update-IR level, asynchronous to clk
- vs_udr  in  1  virtual update-DR level, asynchronous to clk
- ir_in  in  IR_W  instruction register, stable around vs_uir
- sr  in  SR_W  scan register, stable around vs_udr
- cmd_valid  out  1  queue head valid
- cmd_ready  in  1  consumer accepts head
- cmd_ir  out  IR_W  head instruction code
- cmd_act  out  1  head action flag (sr[ACT_BIT] at capture)
- cmd_jdo  out  SR_W  head data word
- jdo  out  SR_W  last accepted data word (legacy view)
- ir_latched  out  IR_W  last captured instruction
- level  out  $clog2(DEPTH+1)  queue occupancy
- overflow  out  1  sticky; update dropped because queue was full
- clr_overflow  in  1  clears overflow
- parity_err  out  1  one-cycle pulse; update rejected for parity

## Operation
- Each strobe passes through SYNC_STAGES flops, then a previous-value flop. rise = sync_last & ~prev & armed.
- armed clears on reset. It sets once sync_last is seen low, so a strobe held high through reset release gives no spurious edge.
- On uir_rise: ir_latched <= ir_in.
- On udr_rise (accepted): jdo <= sr. Push {ir_latched, sr[ACT_BIT], sr}.
  - The pushed ir_latched is the value before any same-cycle uir_rise update.
- Push when udr_rise and (level<DEPTH or pop this cycle).
  - If full with no pop: drop the update, set overflow. jdo is still updated.
- Pop when cmd_valid & cmd_ready. Head outputs are first-word-fall-through from registered storage.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from level.
- overflow: set has priority over clr_overflow in the same cycle.
- cmd_ir/cmd_act/cmd_jdo hold their last values while cmd_valid=0. Consumers qualify them with cmd_valid.

## Timing
- Reset values: cmd_valid=0, cmd_ir=0, cmd_act=0, cmd_jdo=0, jdo=0, ir_latched=0, level=0, overflow=0, parity_err=0. Synchronizers, prev, armed and pointers all clear.
- Reset mid-operation flushes the queue. Queued entries are lost; overflow clears.
- Latency: vs_udr first sampled high at edge N gives jdo and push at edge N+SYNC_STAGES. cmd_valid is high after that edge (3 edges total for SYNC_STAGES=2, edge N included).
- Minimum spacing between vs_udr pulses: SYNC_STAGES+2 clk periods high and the same low. Shorter pulses may be missed.
- One push and one pop are possible per cycle. Throughput is one command per clk.
- cmd_ready may be held high continuously. With cmd_ready=0 the head is stable.

## Configuration
- DEBUG_SLAVE_PARITY_EN defined:
  - sr[SR_W-1] is odd parity over sr[SR_W-2:0].
  - On udr_rise with bad parity: no push, jdo unchanged, overflow unaffected. parity_err pulses high for the cycle after the rise edge.
- Not defined: parity_err is constant 0 and every udr_rise is handled as above.

## Test plan
- Reset, one UIR with ir_in=2, then one UDR with sr[34]=1, sr[31:0]=0xDEADBEEF -> cmd_valid rises 3 clk edges after first UDR sample. cmd_ir=2, cmd_act=1, cmd_jdo[31:0]=0xDEADBEEF, jdo matches, level=1.
- cmd_ready=0, 5 UDR updates with DEPTH=4 -> level=4, overflow=1, jdo=5th word. Then drain with cmd_ready=1 -> words 1..4 in order, level=0.
- Queue full, with cmd_ready=1 in the same cycle as the 5th udr_rise -> push accepted, level stays 4, overflow=0.
- vs_udr held high across reset deassertion -> no push. After vs_udr low then high -> exactly one push.
- UIR and UDR edges in the same clk cycle, ir_latched=1 and ir_in=3 -> pushed cmd_ir=1, ir_latched becomes 3.
- With DEBUG_SLAVE_PARITY_EN, UDR with wrong parity -> parity_err one-cycle pulse, level unchanged, jdo unchanged. Correct parity -> normal push.
